// File: rtl/axis_ramp_pkg.sv
// axis_ramp_pkg: shared widths and codes for the periodic ramp-request generator
package axis_ramp_pkg;
  localparam int CFG_WIDTH_DEF  = 18;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CFG_DISABLED   = 0;
endpackage

// File: rtl/ramp_period_timer.sv
// ramp_period_timer: free-running period counter that ticks on the last cycle of each period
// aclk/aresetn: clock, async active-low reset; cfg_i: period in cycles (0 = off); tick_o: period end this cycle
module ramp_period_timer
  import axis_ramp_pkg::*;
#(
  parameter int CFG_WIDTH = CFG_WIDTH_DEF
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  output logic                 tick_o
);
  logic [CFG_WIDTH-1:0] cnt_q, cnt_d;
  logic                 enabled;
  assign enabled = cfg_i != CFG_WIDTH'(CFG_DISABLED);
  // >= rather than == so a shrinking cfg ends the period at once instead of wrapping
  assign tick_o = enabled && (cnt_q >= cfg_i - CFG_WIDTH'(1));
  always_comb cnt_d = (!enabled || tick_o) ? '0 : cnt_q + CFG_WIDTH'(1);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/axis_ramp_request.sv
// axis_ramp_request: periodic ramp strobe plus one AXI4-Stream sequence-number beat per period
// aclk/aresetn: clock, async active-low reset; cfg: period (0 = off); ramp_rq: registered strobe
// m_axis_tdata/tvalid/tready: request stream, a full slot drops new requests but seq still advances
module axis_ramp_request
  import axis_ramp_pkg::*;
#(
  parameter int CFG_WIDTH  = CFG_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CFG_WIDTH-1:0]  cfg,
  output logic                  ramp_rq,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);
  logic                  tick, load;
  logic                  ramp_rq_q, ramp_rq_d, tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d, tdata_q, tdata_d;
  ramp_period_timer #(.CFG_WIDTH(CFG_WIDTH)) u_tmr (
    .aclk   (aclk),
    .aresetn(aresetn),
    .cfg_i  (cfg),
    .tick_o (tick)
  );
  // slot is free when empty or being drained on this edge
  always_comb begin
    load      = tick && (!tvalid_q || m_axis_tready);
    ramp_rq_d = tick;
    seq_d     = tick ? seq_q + DATA_WIDTH'(1) : seq_q;
    tdata_d   = load ? seq_q : tdata_q;
    tvalid_d  = load || (tvalid_q && !m_axis_tready);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ramp_rq_q <= 1'b0;
      tvalid_q  <= 1'b0;
      seq_q     <= '0;
      tdata_q   <= '0;
    end else begin
      ramp_rq_q <= ramp_rq_d;
      tvalid_q  <= tvalid_d;
      seq_q     <= seq_d;
      tdata_q   <= tdata_d;
    end
  assign ramp_rq       = ramp_rq_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
endmodule

// File: tb/tb_axis_ramp_request.sv
// tb_axis_ramp_request: vector table, corner sequences and randomized model check for axis_ramp_request
module tb_axis_ramp_request;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [17:0] cfg = '0;
  logic        tready = 1'b1;
  logic        ramp_rq, tvalid;
  logic [15:0] tdata;
  int          n_chk = 0, n_err = 0;

  axis_ramp_request #(.CFG_WIDTH(18), .DATA_WIDTH(16)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg          (cfg),
    .ramp_rq      (ramp_rq),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  always #5 aclk = ~aclk;

  // reference: cycles elapsed in the current period, a request slot, and a running request number
  int          m_since;
  logic [15:0] m_seq, m_data;
  logic        m_rq, m_valid;
  wire         m_end = (cfg != 0) && (m_since + 1 >= int'(cfg));
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      m_since <= 0;
      m_seq   <= 0;
      m_data  <= 0;
      m_rq    <= 0;
      m_valid <= 0;
    end else begin
      m_since <= (cfg == 0 || m_end) ? 0 : m_since + 1;
      m_rq    <= m_end;
      if (m_end) m_seq <= m_seq + 16'd1;
      if (m_end && (!m_valid || tready)) begin
        m_data  <= m_seq;
        m_valid <= 1'b1;
      end else if (m_valid && tready) m_valid <= 1'b0;
    end

  typedef struct {
    logic [17:0] cfg;
    logic        rdy;
    int          cycles;
    int          pulses;
    int          beats;
    int          data;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic reset_with(input logic [17:0] c, input logic r);
    aresetn = 1'b0;
    cfg = c;
    tready = r;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    int p, b;
    tbl[0] = '{cfg: 18'd5, rdy: 1'b1, cycles: 50, pulses: 10, beats: 10, data: 9};
    tbl[1] = '{cfg: 18'd1, rdy: 1'b1, cycles: 20, pulses: 20, beats: 20, data: 19};
    tbl[2] = '{cfg: 18'd4, rdy: 1'b0, cycles: 20, pulses: 5, beats: 0, data: 0};
    tbl[3] = '{cfg: 18'd0, rdy: 1'b1, cycles: 30, pulses: 0, beats: 0, data: 0};
    tbl[4] = '{cfg: 18'd7, rdy: 1'b1, cycles: 30, pulses: 4, beats: 4, data: 3};
    tbl[5] = '{cfg: 18'd3, rdy: 1'b0, cycles: 10, pulses: 3, beats: 0, data: 0};

    aresetn = 1'b0;
    #12;
    chk("reset_rq", ramp_rq, 0);
    chk("reset_valid", tvalid, 0);
    chk("reset_data", tdata, 0);

    for (int i = 0; i < 6; i++) begin
      reset_with(tbl[i].cfg, tbl[i].rdy);
      p = 0;
      b = 0;
      repeat (tbl[i].cycles) begin
        step();
        if (ramp_rq) p++;
        if (tvalid && tready) b++;
      end
      chk($sformatf("vec%0d_pulses", i), p, tbl[i].pulses);
      chk($sformatf("vec%0d_beats", i), b, tbl[i].beats);
      chk($sformatf("vec%0d_data", i), tdata, tbl[i].data);
    end

    // stall: beat 0 held, requests 1 and 2 dropped, next beat carries 3
    reset_with(18'd4, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("stall_rq_c%0d", c), ramp_rq, (c % 4) == 0);
      if (c >= 4) begin
        chk($sformatf("stall_valid_c%0d", c), tvalid, 1);
        chk($sformatf("stall_data_c%0d", c), tdata, 0);
      end
    end
    tready = 1'b1;
    step();
    chk("stall_drain_valid", tvalid, 0);
    step();
    step();
    step();
    chk("stall_next_rq", ramp_rq, 1);
    chk("stall_next_valid", tvalid, 1);
    chk("stall_next_data", tdata, 3);

    // shrink period mid-way, then disable
    reset_with(18'd100, 1'b1);
    repeat (60) step();
    cfg = 18'd20;
    step();
    chk("shrink_end_rq", ramp_rq, 1);
    p = 0;
    repeat (19) begin
      step();
      if (ramp_rq) p++;
    end
    chk("shrink_quiet", p, 0);
    step();
    chk("shrink_next_rq", ramp_rq, 1);
    cfg = 18'd0;
    p = 0;
    repeat (40) begin
      step();
      if (ramp_rq) p++;
    end
    chk("disable_pulses", p, 0);
    chk("disable_cnt", dut.u_tmr.cnt_q, 0);

    // pending beat survives cfg going to 0
    reset_with(18'd3, 1'b0);
    repeat (3) step();
    cfg = 18'd0;
    repeat (10) step();
    chk("off_pending_valid", tvalid, 1);
    chk("off_pending_rq", ramp_rq, 0);
    tready = 1'b1;
    step();
    chk("off_drained_valid", tvalid, 0);

    // asynchronous reset with a nonzero beat pending
    reset_with(18'd2, 1'b1);
    repeat (7) step();
    tready = 1'b0;
    step();
    chk("pre_areset_data", tdata, 3);
    chk("pre_areset_valid", tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("areset_rq", ramp_rq, 0);
    chk("areset_valid", tvalid, 0);
    chk("areset_data", tdata, 0);
    @(negedge aclk);
    tready = 1'b1;
    aresetn = 1'b1;
    step();
    chk("post_areset_c1_rq", ramp_rq, 0);
    step();
    chk("post_areset_c2_rq", ramp_rq, 1);
    chk("post_areset_c2_valid", tvalid, 1);
    chk("post_areset_c2_data", tdata, 0);

    // sequence wrap at one request per cycle
    reset_with(18'd1, 1'b1);
    repeat (65536) step();
    chk("wrap_last_data", tdata, 65535);
    step();
    chk("wrap_data", tdata, 0);
    chk("wrap_valid", tvalid, 1);
    chk("wrap_rq", ramp_rq, 1);

    // randomized cfg changes and backpressure against the reference
    reset_with(18'd3, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step();
      chk("rnd_rq", ramp_rq, m_rq);
      chk("rnd_valid", tvalid, m_valid);
      chk("rnd_data", tdata, m_data);
      if ($urandom_range(0, 19) == 0) cfg = 18'($urandom_range(0, 9));
      tready = $urandom_range(0, 3) != 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
